mem_dump_tx: RTL

Post-run result dumper for the core. When the core raises `core_end`, this block reads a fixed window of data RAM through the io-side memory port (`memread_io` / `data_ready_io`). It then transmits each word over a UART line, little-endian, 8N1. It is the read/transmit counterpart to the program-load path, which receives over `rxd` and writes memory, and it lets the host fetch results without halting the board.

---
 rtl/mem_dump_pkg.sv | 27 ++
 rtl/mem_dump_tx_uart.sv | 106 ++++++++++
 rtl/mem_dump_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// ============================================================================
// Module : mem_dump_pkg
// Brief  : Shared states and UART frame constants for the memory dumper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int c_START_BITS     = 1;
    localparam int c_DATA_BITS      = 8;
    localparam int c_STOP_BITS      = 1;
    localparam int c_BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/mem_dump_tx_uart.sv
// ============================================================================
// Module : uart_tx_byte
// Brief  : 8N1 byte transmitter; accepts a new byte on the final stop cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
    import mem_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [c_DATA_BITS-1:0] i_data,
    output logic                   o_ready,
    output logic                   o_txd
);

    localparam logic [15:0] c_CNT_MAX    = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  c_START_LAST = 4'(c_START_BITS - 1);
    localparam logic [3:0]  c_DATA_LAST  = 4'(c_START_BITS + c_DATA_BITS - 1);
    localparam logic [3:0]  c_LAST_SLOT  = 4'(c_START_BITS + c_DATA_BITS + c_STOP_BITS - 1);

    state_t                 r_state, w_state_nxt;
    logic [15:0]            r_cnt, w_cnt_nxt;
    logic [3:0]             r_slot, w_slot_nxt;
    logic [c_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                   r_txd, w_txd_nxt;
    logic                   w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_MAX);
    // Ready on the last stop cycle lets the next frame follow with no gap.
    assign o_ready   = (r_state == S_IDLE) ||
                       ((r_state == S_STOP) && w_bit_end && (r_slot == c_LAST_SLOT));
    assign o_txd     = r_txd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_slot  <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_slot  <= w_slot_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? 16'd0 : r_cnt + 16'd1;
        w_slot_nxt  = w_bit_end ? r_slot + 4'd1 : r_slot;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_slot_nxt = '0;
                w_txd_nxt  = 1'b1;
            end
            S_START: begin
                if (w_bit_end && (r_slot == c_START_LAST)) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    w_txd_nxt   = r_shift[1];
                    if (r_slot == c_DATA_LAST) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            S_STOP: begin
                w_txd_nxt = 1'b1;
                if (w_bit_end && (r_slot == c_LAST_SLOT)) begin
                    w_state_nxt = S_IDLE;
                    w_slot_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
        if (i_start && o_ready) begin
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
            w_shift_nxt = i_data;
            w_cnt_nxt   = '0;
            w_slot_nxt  = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_dump_tx.sv
// ============================================================================
// Module : mem_dump_tx
// Brief  : On core_end rising, reads a RAM window and streams it out over UART.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_dump_tx
    import mem_dump_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] DUMP_BASE    = 32'h0000_0000,
    parameter int          DUMP_WORDS   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_end,
    output logic        memread_io,
    output logic [31:0] addr_io,
    input  logic        data_ready_io,
    input  logic [31:0] data_from_memory_io,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  c_LAST_BYTE = 2'(c_BYTES_PER_WORD - 1);
    localparam logic [15:0] c_WORDS     = 16'(DUMP_WORDS);

    state_t      r_state, w_state_nxt;
    logic        r_core_prev, r_armed;
    logic [15:0] r_index;
    logic [31:0] r_addr;
    logic        r_memread, r_busy, r_done;
    logic [23:0] r_word;
    logic [1:0]  r_byte;

    logic        w_rise, w_accept, w_more_bytes, w_tx_start, w_tx_ready, w_last_word;
    logic [7:0]  w_tx_data;
    logic [15:0] w_index_nxt;

    // r_armed keeps a level already high at reset release from counting as an edge.
    assign w_rise       = core_end & ~r_core_prev & r_armed;
    assign w_accept     = (r_state == S_REQ) && data_ready_io;
    assign w_more_bytes = (r_state == S_START) && w_tx_ready && (r_byte != c_LAST_BYTE);
    assign w_tx_start   = w_accept || w_more_bytes;
    assign w_tx_data    = w_accept ? data_from_memory_io[7:0] : r_word[7:0];
    assign w_index_nxt  = r_index + 16'd1;
    assign w_last_word  = (w_index_nxt == c_WORDS);

    assign memread_io = r_memread;
    assign addr_io    = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_tx_start),
        .i_data (w_tx_data),
        .o_ready(w_tx_ready),
        .o_txd  (txd)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // S_START here spans the whole byte frame; bit phases live in uart_tx_byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_REQ;
            S_REQ:   if (data_ready_io) w_state_nxt = S_START;
            S_START: if (w_tx_ready && (r_byte == c_LAST_BYTE)) w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = w_last_word ? S_DONE : S_REQ;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_prev <= 1'b0;
            r_armed     <= 1'b0;
            r_index     <= '0;
            r_addr      <= '0;
            r_memread   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_word      <= '0;
            r_byte      <= '0;
        end else begin
            r_core_prev <= core_end;
            if (!core_end) r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_index   <= '0;
                        r_addr    <= DUMP_BASE;
                        r_memread <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (data_ready_io) begin
                        r_memread <= 1'b0;
                        r_word    <= data_from_memory_io[31:8];
                        r_byte    <= '0;
                    end
                end
                S_START: begin
                    if (w_more_bytes) begin
                        r_byte <= r_byte + 2'd1;
                        r_word <= {8'h00, r_word[23:8]};
                    end
                end
                S_NEXT: begin
                    r_index <= w_index_nxt;
                    if (w_last_word) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_memread <= 1'b1;
                        r_addr    <= r_addr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
